tron_arena: RTL



---
 rtl/tron_arena.sv | 332 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/tron_arena.sv
// tron_arena: N-player light-cycle engine with board memory, tick-paced moves,
// collision/winner detection and one serial plot stream. Option: TRON_WRAP_EN.
module tron_arena #(
    parameter int NUM_PLAYERS = 2,
    parameter int BOARD_W     = 160,
    parameter int BOARD_H     = 120,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int TICK_DIV    = 2500000
) (
    input  logic                     CLOCK_50,
    input  logic                     resetn,
    input  logic                     start,
    input  logic [4*NUM_PLAYERS-1:0] dir_req,
    output logic [X_W-1:0]           plot_x,
    output logic [Y_W-1:0]           plot_y,
    output logic [2:0]               plot_colour,
    output logic                     plot_en,
    output logic [NUM_PLAYERS-1:0]   alive,
    output logic                     game_over,
    output logic [2:0]               winner
);
    localparam int CELLS = BOARD_W * BOARD_H;
    localparam int A_W   = $clog2(CELLS);
    localparam int T_W   = $clog2(TICK_DIV);
    localparam int P_W   = $clog2(NUM_PLAYERS);
    localparam logic [X_W-1:0] LAST_X  = X_W'(BOARD_W - 1);
    localparam logic [Y_W-1:0] LAST_Y  = Y_W'(BOARD_H - 1);
    localparam logic [Y_W-1:0] SPAWN_Y = Y_W'(BOARD_H / 2);
    localparam logic [P_W-1:0] LAST_P  = P_W'(NUM_PLAYERS - 1);
    localparam logic [T_W-1:0] TICK_LAST = T_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SPAWN, S_WAIT, S_MOVE, S_DONE} state_t;
    typedef enum logic [2:0] {PH_A, PH_BR, PH_BC, PH_C, PH_END} phase_t;
    // Encoding makes the reverse heading the bitwise complement.
    typedef enum logic [1:0] {H_RIGHT, H_UP, H_DOWN, H_LEFT} head_t;

    state_t state_q, state_d;
    phase_t phase_q, phase_d;
    logic [P_W-1:0] idx_q, idx_d;
    logic [T_W-1:0] tick_q, tick_d;
    logic [X_W-1:0] cx_q, cx_d;
    logic [Y_W-1:0] cy_q, cy_d;
    logic [X_W-1:0] px_q [NUM_PLAYERS];
    logic [X_W-1:0] px_d [NUM_PLAYERS];
    logic [Y_W-1:0] py_q [NUM_PLAYERS];
    logic [Y_W-1:0] py_d [NUM_PLAYERS];
    logic [X_W-1:0] nx_q [NUM_PLAYERS];
    logic [X_W-1:0] nx_d [NUM_PLAYERS];
    logic [Y_W-1:0] ny_q [NUM_PLAYERS];
    logic [Y_W-1:0] ny_d [NUM_PLAYERS];
    head_t head_q [NUM_PLAYERS];
    head_t head_d [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] alive_q, alive_d, die_q, die_d;
    logic game_over_q, game_over_d;
    logic [2:0] winner_q, winner_d;
    logic [X_W-1:0] plot_x_q, plot_x_d;
    logic [Y_W-1:0] plot_y_q, plot_y_d;
    logic [2:0] plot_c_q, plot_c_d;
    logic plot_en_q, plot_en_d;

    logic mem [CELLS];
    logic rd_q;
    logic mem_we, mem_wd;
    logic [A_W-1:0] mem_addr;
    logic wall, hit;
    logic [3:0] req;

    function automatic logic [A_W-1:0] cell_addr(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y);
        return A_W'(int'(y) * BOARD_W + int'(x));
    endfunction

    function automatic logic [X_W-1:0] spawn_x(input int i);
        return X_W'((i + 1) * BOARD_W / (NUM_PLAYERS + 1));
    endfunction

    function automatic logic [X_W-1:0] next_x(input logic [X_W-1:0] x, input head_t h);
        logic [X_W-1:0] r;
        r = x;
`ifdef TRON_WRAP_EN
        if (h == H_RIGHT) r = (x == LAST_X) ? '0 : x + X_W'(1);
        if (h == H_LEFT)  r = (x == '0) ? LAST_X : x - X_W'(1);
`else
        if (h == H_RIGHT) r = x + X_W'(1);
        if (h == H_LEFT)  r = x - X_W'(1);
`endif
        return r;
    endfunction

    function automatic logic [Y_W-1:0] next_y(input logic [Y_W-1:0] y, input head_t h);
        logic [Y_W-1:0] r;
        r = y;
`ifdef TRON_WRAP_EN
        if (h == H_DOWN) r = (y == LAST_Y) ? '0 : y + Y_W'(1);
        if (h == H_UP)   r = (y == '0) ? LAST_Y : y - Y_W'(1);
`else
        if (h == H_DOWN) r = y + Y_W'(1);
        if (h == H_UP)   r = y - Y_W'(1);
`endif
        return r;
    endfunction

    // Single-port board: a write cycle skips the read.
    always_ff @(posedge CLOCK_50) begin
        if (mem_we) mem[mem_addr] <= mem_wd;
        else        rd_q <= mem[mem_addr];
    end

    // State, player and output registers with synchronous active-low reset.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            phase_q <= PH_A;
            idx_q <= '0;
            tick_q <= '0;
            cx_q <= '0;
            cy_q <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                px_q[i] <= '0;
                py_q[i] <= '0;
                nx_q[i] <= '0;
                ny_q[i] <= '0;
                head_q[i] <= (i % 2 == 1) ? H_DOWN : H_UP;
            end
            alive_q <= '0;
            die_q <= '0;
            game_over_q <= 1'b0;
            winner_q <= '0;
            plot_x_q <= '0;
            plot_y_q <= '0;
            plot_c_q <= '0;
            plot_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q <= idx_d;
            tick_q <= tick_d;
            cx_q <= cx_d;
            cy_q <= cy_d;
            px_q <= px_d;
            py_q <= py_d;
            nx_q <= nx_d;
            ny_q <= ny_d;
            head_q <= head_d;
            alive_q <= alive_d;
            die_q <= die_d;
            game_over_q <= game_over_d;
            winner_q <= winner_d;
            plot_x_q <= plot_x_d;
            plot_y_q <= plot_y_d;
            plot_c_q <= plot_c_d;
            plot_en_q <= plot_en_d;
        end
    end

    // Heading updates, round sequencing, board access and plot generation.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d = idx_q;
        tick_d = tick_q;
        cx_d = cx_q;
        cy_d = cy_q;
        px_d = px_q;
        py_d = py_q;
        nx_d = nx_q;
        ny_d = ny_q;
        head_d = head_q;
        alive_d = alive_q;
        die_d = die_q;
        game_over_d = game_over_q;
        winner_d = winner_q;
        plot_x_d = plot_x_q;
        plot_y_d = plot_y_q;
        plot_c_d = plot_c_q;
        plot_en_d = 1'b0;
        mem_we = 1'b0;
        mem_wd = 1'b0;
        mem_addr = '0;
        wall = 1'b0;
        hit = 1'b0;
        req = '0;

        for (int i = 0; i < NUM_PLAYERS; i++) begin
            req = dir_req[4*i +: 4];
            if ($onehot(req) && !req[~head_q[i]])
                head_d[i] = head_t'({req[3] | req[2], req[3] | req[1]});
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    cx_d = '0;
                    cy_d = '0;
                    alive_d = '0;
                    game_over_d = 1'b0;
                    winner_d = '0;
                end
            end
            S_CLEAR: begin
`ifndef TRON_WRAP_EN
                wall = (cx_q == '0) || (cx_q == LAST_X) ||
                       (cy_q == '0) || (cy_q == LAST_Y);
`endif
                mem_we = 1'b1;
                mem_wd = wall;
                mem_addr = cell_addr(cx_q, cy_q);
                plot_en_d = 1'b1;
                plot_x_d = cx_q;
                plot_y_d = cy_q;
                plot_c_d = wall ? 3'b111 : 3'b000;
                if (cx_q == LAST_X) begin
                    cx_d = '0;
                    if (cy_q == LAST_Y) begin
                        state_d = S_SPAWN;
                        idx_d = '0;
                    end else begin
                        cy_d = cy_q + Y_W'(1);
                    end
                end else begin
                    cx_d = cx_q + X_W'(1);
                end
            end
            S_SPAWN: begin
                px_d[idx_q] = spawn_x(int'(idx_q));
                py_d[idx_q] = SPAWN_Y;
                head_d[idx_q] = idx_q[0] ? H_DOWN : H_UP;
                mem_we = 1'b1;
                mem_wd = 1'b1;
                mem_addr = cell_addr(spawn_x(int'(idx_q)), SPAWN_Y);
                plot_en_d = 1'b1;
                plot_x_d = spawn_x(int'(idx_q));
                plot_y_d = SPAWN_Y;
                plot_c_d = 3'(idx_q) + 3'd1;
                if (idx_q == LAST_P) begin
                    alive_d = '1;
                    state_d = S_WAIT;
                    tick_d = '0;
                end else begin
                    idx_d = idx_q + P_W'(1);
                end
            end
            S_WAIT: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    state_d = S_MOVE;
                    phase_d = PH_A;
                    idx_d = '0;
                    die_d = '0;
                end else begin
                    tick_d = tick_q + T_W'(1);
                end
            end
            S_MOVE: begin
                // The tick period keeps running; MOVE ends well before the next wrap.
                tick_d = tick_q + T_W'(1);
                unique case (phase_q)
                    PH_A: begin
                        if (alive_q[idx_q]) begin
                            nx_d[idx_q] = next_x(px_q[idx_q], head_q[idx_q]);
                            ny_d[idx_q] = next_y(py_q[idx_q], head_q[idx_q]);
                        end
                        idx_d = (idx_q == LAST_P) ? '0 : idx_q + P_W'(1);
                        if (idx_q == LAST_P) phase_d = PH_BR;
                    end
                    PH_BR, PH_BC: begin
                        mem_addr = cell_addr(nx_q[idx_q], ny_q[idx_q]);
                        if (phase_q == PH_BR && alive_q[idx_q]) begin
                            phase_d = PH_BC;
                        end else begin
                            if (phase_q == PH_BC) begin
                                hit = rd_q;
                                for (int j = 0; j < NUM_PLAYERS; j++)
                                    if (j != int'(idx_q) && alive_q[j] &&
                                        nx_q[j] == nx_q[idx_q] && ny_q[j] == ny_q[idx_q])
                                        hit = 1'b1;
                                die_d[idx_q] = hit;
                            end
                            if (idx_q == LAST_P) begin
                                phase_d = PH_C;
                                idx_d = '0;
                                alive_d = alive_q & ~die_d;
                            end else begin
                                phase_d = PH_BR;
                                idx_d = idx_q + P_W'(1);
                            end
                        end
                    end
                    PH_C: begin
                        if (alive_q[idx_q]) begin
                            mem_we = 1'b1;
                            mem_wd = 1'b1;
                            mem_addr = cell_addr(nx_q[idx_q], ny_q[idx_q]);
                            px_d[idx_q] = nx_q[idx_q];
                            py_d[idx_q] = ny_q[idx_q];
                            plot_en_d = 1'b1;
                            plot_x_d = nx_q[idx_q];
                            plot_y_d = ny_q[idx_q];
                            plot_c_d = 3'(idx_q) + 3'd1;
                        end
                        idx_d = (idx_q == LAST_P) ? '0 : idx_q + P_W'(1);
                        if (idx_q == LAST_P) phase_d = PH_END;
                    end
                    PH_END: begin
                        if ($countones(alive_q) <= 1) begin
                            state_d = S_DONE;
                            game_over_d = 1'b1;
                            winner_d = '0;
                            for (int i = 0; i < NUM_PLAYERS; i++)
                                if (alive_q[i]) winner_d = 3'(i + 1);
                        end else begin
                            state_d = S_WAIT;
                        end
                        phase_d = PH_A;
                    end
                    default: phase_d = PH_A;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign plot_x = plot_x_q;
    assign plot_y = plot_y_q;
    assign plot_colour = plot_c_q;
    assign plot_en = plot_en_q;
    assign alive = alive_q;
    assign game_over = game_over_q;
    assign winner = winner_q;
endmodule
